// File: rtl/mem_responder.sv
// Word-array memory responder behind valid/ready request and response channels.
// One request is outstanding at a time; the access is committed after LATENCY wait cycles.
module mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IdxW      = $clog2(DEPTH);
  localparam logic [31:0] SpanBytes = 32'(4 * DEPTH);
  localparam logic [3:0]  CntLoad   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wen_q, wen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic            accept;
  logic            commit;
  logic            acc_wen;
  logic [31:0]     acc_addr;
  logic [31:0]     acc_wdata;
  logic [3:0]      acc_wmask;
  logic [31:0]     acc_off;
  logic            in_range;
  logic [IdxW-1:0] acc_idx;

  assign req_ready = reset && (state_q == StIdle);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // With zero latency the access happens at the accepting edge, straight from the inputs.
  always_comb begin
    if (state_q == StIdle) begin
      acc_wen   = req_wen;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_wmask = req_wmask;
    end else begin
      acc_wen   = wen_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_wmask = wmask_q;
    end
  end

  // Unsigned wrap of the offset folds the lower bound into the single compare.
  assign acc_off  = acc_addr - BASE_ADDR;
  assign in_range = acc_off < SpanBytes;
  assign acc_idx  = acc_off[IdxW+1:2];

  assign commit = ((LATENCY == 0) && (state_q == StIdle) && accept) ||
                  ((state_q == StWait) && (cnt_q == 4'd0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          wen_d   = req_wen;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wmask_d = req_wmask;
          if (LATENCY == 0) begin
            state_d = StResp;
          end else begin
            cnt_d   = CntLoad;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (commit) begin
      err_d   = !in_range;
      rdata_d = (in_range && !acc_wen) ? mem[acc_idx] : 32'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      wen_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wmask_q <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is deliberately not reset; commit cannot fire while reset holds the FSM idle.
  always_ff @(posedge clk) begin
    if (commit && in_range && acc_wen) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wmask[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
